// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions.
// Access-size encodings and field-width helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  // Field width in bits for an access size: 8, 16, 32 or 64.
  function automatic int field_bits(input logic [1:0] size);
    return 8 << size;
  endfunction

endpackage

// File: rtl/meta_fifo.sv
// Synchronous FIFO holding per-load metadata.
// Pointers wrap modulo DEPTH; clr restarts at entry 0.
module meta_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_align_extend.sv
// Load-return unit: pairs queued metadata with cache beats,
// selects, aligns and extends the field into a registered stage.
module load_align_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int OFFW = $clog2(WIDTH / 8),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [OFFW-1:0]  req_offset,
  input  logic [4:0]       req_rd,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_err,
  output logic [CW-1:0]    pending
);

  localparam int MW = 2 + 1 + OFFW + 5;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [MW-1:0]   meta_in;
  logic [MW-1:0]   meta_out;

  logic [1:0]      h_size;
  logic            h_sgn;
  logic [OFFW-1:0] h_off;
  logic [4:0]      h_rd;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] ext;
  logic             sbit;
  logic             bad;
  int               fbits;

  assign req_ready  = !full && !flush;
  assign push       = req_valid && req_ready;
  assign resp_ready = !empty && !flush && (!out_valid || out_ready);
  assign pop        = resp_valid && resp_ready;

  assign meta_in = {req_size, req_signed, req_offset, req_rd};

  assign h_size = meta_out[MW-1 -: 2];
  assign h_sgn  = meta_out[OFFW+5];
  assign h_off  = meta_out[OFFW+4:5];
  assign h_rd   = meta_out[4:0];

  meta_fifo #(
    .DEPTH(DEPTH),
    .W    (MW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .din  (meta_in),
    .dout (meta_out),
    .full (full),
    .empty(empty),
    .count(pending)
  );

  assign shifted = resp_data >> {h_off, 3'b000};

  // Field mask, sign bit, alignment check and extension.
  always_comb begin
    fbits = field_bits(h_size);
    mask  = '0;
    sbit  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i < fbits);
      if (i == fbits - 1) begin
        sbit = shifted[i];
      end
    end
    bad = (fbits > WIDTH) ||
          ((int'(h_off) % (fbits / 8)) != 0);
    ext = shifted & mask;
    if (h_sgn && sbit) begin
      ext = ext | ~mask;
    end
  end

  // Output stage: load on pop, drop on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= bad ? '0 : ext;
      out_rd    <= h_rd;
      out_err   <= bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_align_extend.sv
// Bench for load_align_extend: vector table, corner
// sequences and a randomized run against a byte-level model.
module tb_load_align_extend;

  typedef struct {
    bit          w64;
    logic [1:0]  size;
    bit          sgn;
    int          off;
    logic [4:0]  rd;
    logic [63:0] beat;
    logic [63:0] exp;
    bit          err;
  } vec_t;

  typedef struct {
    logic [1:0] size;
    bit         sgn;
    int         off;
    logic [4:0] rd;
  } meta_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, req_valid, req_signed;
  logic [1:0]  req_size, req_offset;
  logic [4:0]  req_rd;
  logic        resp_valid, out_ready;
  logic [31:0] resp_data;
  logic        req_ready, resp_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [2:0]  pending;

  logic        w_rst, w_flush, w_req_valid, w_req_signed;
  logic [1:0]  w_req_size;
  logic [2:0]  w_req_offset;
  logic [4:0]  w_req_rd;
  logic        w_resp_valid, w_out_ready;
  logic [63:0] w_resp_data;
  logic        w_req_ready, w_resp_ready, w_out_valid, w_out_err;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_rd;
  logic [2:0]  w_pending;

  load_align_extend #(.WIDTH(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_signed(req_signed),
    .req_offset(req_offset), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_err(out_err), .pending(pending)
  );

  load_align_extend #(.WIDTH(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(w_rst), .flush(w_flush),
    .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_size(w_req_size), .req_signed(w_req_signed),
    .req_offset(w_req_offset), .req_rd(w_req_rd),
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
    .resp_data(w_resp_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_rd(w_out_rd),
    .out_err(w_out_err), .pending(w_pending)
  );

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[14];
  meta_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-oriented reference: gather bytes, then extend.
  function automatic logic [63:0] model(
    input logic [63:0] beat, input int w, input int size,
    input bit sgn, input int off, output bit err);
    int nb;
    logic [63:0] v;
    nb = 1 << size;
    err = 1'b0;
    v = '0;
    if (nb * 8 > w || off % nb != 0) begin
      err = 1'b1;
      return '0;
    end
    for (int k = 0; k < nb; k++) v[k*8 +: 8] = beat[(off+k)*8 +: 8];
    if (sgn && nb * 8 < w && v[nb*8-1])
      for (int k = nb * 8; k < 64; k++) v[k] = 1'b1;
    if (w == 32) v[63:32] = '0;
    return v;
  endfunction

  task automatic exp_chk(input string nm, input meta_t m,
                         input logic [31:0] beat);
    logic [63:0] e;
    bit ee;
    e = model({32'h0, beat}, 32, m.size, m.sgn, m.off, ee);
    chk({nm, " data"}, {32'h0, out_data}, e);
    chk({nm, " rd"}, {59'h0, out_rd}, {59'h0, m.rd});
    chk({nm, " err"}, {63'h0, out_err}, {63'h0, ee});
  endtask

  task automatic push32(input meta_t m);
    req_valid  = 1'b1;
    req_size   = m.size;
    req_signed = m.sgn;
    req_offset = 2'(m.off);
    req_rd     = m.rd;
    step();
    req_valid  = 1'b0;
  endtask

  function automatic meta_t rnd_meta(input bit aligned, input int rd);
    meta_t m;
    m.size = aligned ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    m.off  = $urandom_range(0, 3);
    if (aligned) m.off = m.off & ~((1 << m.size) - 1);
    m.sgn  = 1'($urandom_range(0, 1));
    m.rd   = 5'(rd);
    return m;
  endfunction

  task automatic run32(input vec_t v);
    meta_t m;
    m.size = v.size; m.sgn = v.sgn; m.off = v.off; m.rd = v.rd;
    push32(m);
    chk("tbl32 pending push", {61'h0, pending}, 64'd1);
    resp_valid = 1'b1;
    resp_data  = v.beat[31:0];
    step();
    resp_valid = 1'b0;
    chk("tbl32 valid", {63'h0, out_valid}, 64'd1);
    chk("tbl32 data", {32'h0, out_data}, v.exp);
    chk("tbl32 rd", {59'h0, out_rd}, {59'h0, v.rd});
    chk("tbl32 err", {63'h0, out_err}, {63'h0, v.err});
    chk("tbl32 pending pop", {61'h0, pending}, 64'd0);
    step();
  endtask

  task automatic run64(input vec_t v);
    w_req_valid  = 1'b1;
    w_req_size   = v.size;
    w_req_signed = v.sgn;
    w_req_offset = 3'(v.off);
    w_req_rd     = v.rd;
    step();
    w_req_valid  = 1'b0;
    w_resp_valid = 1'b1;
    w_resp_data  = v.beat;
    step();
    w_resp_valid = 1'b0;
    chk("tbl64 valid", {63'h0, w_out_valid}, 64'd1);
    chk("tbl64 data", w_out_data, v.exp);
    chk("tbl64 rd", {59'h0, w_out_rd}, {59'h0, v.rd});
    chk("tbl64 err", {63'h0, w_out_err}, {63'h0, v.err});
    chk("tbl64 pending", {61'h0, w_pending}, 64'd0);
    step();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " req_ready"}, {63'h0, req_ready}, 64'd1);
    chk({nm, " resp_ready"}, {63'h0, resp_ready}, 64'd0);
    chk({nm, " out_valid"}, {63'h0, out_valid}, 64'd0);
    chk({nm, " out_data"}, {32'h0, out_data}, 64'd0);
    chk({nm, " out_rd"}, {59'h0, out_rd}, 64'd0);
    chk({nm, " out_err"}, {63'h0, out_err}, 64'd0);
    chk({nm, " pending"}, {61'h0, pending}, 64'd0);
  endtask

  initial begin
    meta_t m;
    logic [31:0] beats[4];
    logic [63:0] m_data;
    logic [4:0] m_rd;
    bit m_err, m_ov, e_rq, e_rs;

    tbl[0]  = '{0, 2'd0, 1, 3, 5'd7,  64'h80FF_0000, 64'hFFFF_FF80, 0};
    tbl[1]  = '{0, 2'd1, 0, 2, 5'd8,  64'h80FF_0000, 64'h0000_80FF, 0};
    tbl[2]  = '{0, 2'd2, 1, 0, 5'd9,  64'h80FF_0000, 64'h80FF_0000, 0};
    tbl[3]  = '{0, 2'd1, 1, 1, 5'd10, 64'h80FF_0000, 64'h0, 1};
    tbl[4]  = '{0, 2'd3, 0, 0, 5'd11, 64'h80FF_0000, 64'h0, 1};
    tbl[5]  = '{0, 2'd0, 1, 1, 5'd12, 64'h1234_5678, 64'h56, 0};
    tbl[6]  = '{0, 2'd1, 1, 0, 5'd13, 64'h0000_8001, 64'hFFFF_8001, 0};
    tbl[7]  = '{0, 2'd0, 0, 2, 5'd14, 64'h1234_5678, 64'h34, 0};
    tbl[8]  = '{1, 2'd2, 1, 4, 5'd15, 64'h8000_0001_0000_0000,
                64'hFFFF_FFFF_8000_0001, 0};
    tbl[9]  = '{1, 2'd3, 1, 0, 5'd16, 64'h8000_0001_0000_0000,
                64'h8000_0001_0000_0000, 0};
    tbl[10] = '{1, 2'd2, 0, 4, 5'd17, 64'h8000_0001_0000_0000,
                64'h0000_0000_8000_0001, 0};
    tbl[11] = '{1, 2'd1, 1, 6, 5'd18, 64'h8000_0001_0000_0000,
                64'hFFFF_FFFF_FFFF_8000, 0};
    tbl[12] = '{1, 2'd2, 1, 2, 5'd19, 64'h8000_0001_0000_0000, 64'h0, 1};
    tbl[13] = '{1, 2'd0, 1, 7, 5'd20, 64'h8000_0001_0000_0000,
                64'hFFFF_FFFF_FFFF_FF80, 0};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
    req_size = '0; req_offset = '0; req_rd = '0;
    resp_valid = 1'b0; resp_data = '0; out_ready = 1'b1;
    w_rst = 1'b1; w_flush = 1'b0; w_req_valid = 1'b0;
    w_req_signed = 1'b0; w_req_size = '0; w_req_offset = '0;
    w_req_rd = '0; w_resp_valid = 1'b0; w_resp_data = '0;
    w_out_ready = 1'b1;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    w_rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      if (tbl[i].w64) run64(tbl[i]);
      else run32(tbl[i]);
    end

    // Fill to full, then push+pop while full, stall, stream.
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      m = rnd_meta(1, 20 + i);
      mq.push_back(m);
      beats[i] = $urandom;
      push32(m);
      chk("fill pending", {61'h0, pending}, 64'(i + 1));
    end
    req_valid = 1'b1;
    req_rd = 5'd31;
    resp_valid = 1'b1;
    resp_data = beats[0];
    #1;
    chk("full req_ready", {63'h0, req_ready}, 64'd0);
    step();
    req_valid = 1'b0;
    chk("full no push", {61'h0, pending}, 64'd3);
    chk("full valid", {63'h0, out_valid}, 64'd1);
    exp_chk("full first", mq[0], beats[0]);
    out_ready = 1'b0;
    resp_data = beats[1];
    #1;
    chk("stall resp_ready", {63'h0, resp_ready}, 64'd0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk("stall valid", {63'h0, out_valid}, 64'd1);
      chk("stall pending", {61'h0, pending}, 64'd3);
      exp_chk("stall hold", mq[0], beats[0]);
    end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      resp_data = beats[j];
      step();
      chk("stream valid", {63'h0, out_valid}, 64'd1);
      exp_chk("stream", mq[j], beats[j]);
    end
    resp_valid = 1'b0;
    step();
    chk("drain valid", {63'h0, out_valid}, 64'd0);
    chk("drain pending", {61'h0, pending}, 64'd0);

    // Flush with 3 pending and a held result.
    for (int i = 0; i < 4; i++) push32(rnd_meta(1, i + 1));
    out_ready = 1'b0;
    resp_valid = 1'b1;
    resp_data = $urandom;
    step();
    chk("preflush pending", {61'h0, pending}, 64'd3);
    chk("preflush valid", {63'h0, out_valid}, 64'd1);
    flush = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush req_ready", {63'h0, req_ready}, 64'd0);
    chk("flush resp_ready", {63'h0, resp_ready}, 64'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    resp_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush pending", {61'h0, pending}, 64'd0);
    chk("flush valid", {63'h0, out_valid}, 64'd0);
    run32(tbl[0]);

    // Reset mid-stream with a nonzero held result.
    m = '{2'd2, 1'b0, 0, 5'd9};
    push32(m);
    push32(m);
    out_ready = 1'b0;
    resp_valid = 1'b1;
    resp_data = 32'hDEAD_BEEF;
    step();
    resp_valid = 1'b0;
    chk("prerst data", {32'h0, out_data}, 64'hDEAD_BEEF);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Randomized traffic against the model.
    mq.delete();
    m_ov = 1'b0; m_data = '0; m_rd = '0; m_err = 1'b0;
    for (int c = 0; c < 800; c++) begin
      chk("rnd valid", {63'h0, out_valid}, {63'h0, m_ov});
      if (m_ov) begin
        chk("rnd data", {32'h0, out_data}, m_data);
        chk("rnd rd", {59'h0, out_rd}, {59'h0, m_rd});
        chk("rnd err", {63'h0, out_err}, {63'h0, m_err});
      end
      chk("rnd pending", {61'h0, pending}, 64'(mq.size()));
      m = rnd_meta($urandom_range(0, 3) != 0, $urandom_range(0, 31));
      flush      = ($urandom_range(0, 49) == 0);
      req_valid  = 1'($urandom_range(0, 1));
      req_size   = m.size;
      req_signed = m.sgn;
      req_offset = 2'(m.off);
      req_rd     = m.rd;
      resp_valid = 1'($urandom_range(0, 1));
      resp_data  = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      e_rq = !flush && mq.size() < 4;
      e_rs = !flush && mq.size() > 0 && (!m_ov || out_ready);
      chk("rnd req_ready", {63'h0, req_ready}, {63'h0, e_rq});
      chk("rnd resp_ready", {63'h0, resp_ready}, {63'h0, e_rs});
      if (flush) begin
        mq.delete();
        m_ov = 1'b0;
      end else begin
        if (resp_valid && e_rs) begin
          meta_t h;
          h = mq.pop_front();
          m_data = model({32'h0, resp_data}, 32, h.size, h.sgn,
                         h.off, m_err);
          m_rd = h.rd;
          m_ov = 1'b1;
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
        if (req_valid && e_rq) mq.push_back(m);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
